// File: rtl/ccip_if_pkg.sv
// rtl/ccip_if_pkg.sv - CCI-P channel header and interface structures
//
// Purpose: packed CCI-P Rx/Tx channel types shared by the FIU-side and
// AFU-side interfaces. Field names follow the CCI-P naming.
// Ports: none (package).

package ccip_if_pkg;

  typedef logic [511:0] t_ccip_clData;
  typedef logic [63:0]  t_ccip_mmioData;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [8:0]   t_ccip_tid;

  // Tx request / response headers
  typedef struct packed {
    logic [3:0]   req_type;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [3:0]   req_type;
    logic         sop;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  // Rx response headers
  typedef struct packed {
    logic [3:0]  resp_type;
    t_ccip_mdata mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [3:0]  resp_type;
    t_ccip_mdata mdata;
  } t_ccip_c1_RspMemHdr;

  // Tx channels
  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  // Rx channels
  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

endpackage

// File: rtl/ccip_pipe_pkg.sv
// rtl/ccip_pipe_pkg.sv - shared constants and types for the CCI-P pipe buffer
//
// Purpose: default FIFO sizing, occupancy width helper and debug status type.
// Ports: none (package).

package ccip_pipe_pkg;

  localparam int CCIP_PIPE_TX_DEPTH = 64;
  localparam int CCIP_PIPE_AF_SLACK = 8;

  // Occupancy needs one extra bit so that a completely full FIFO (count ==
  // depth) is representable.
  function automatic int ccip_pipe_occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CCIP_PIPE_OCC_W = ccip_pipe_occ_w(CCIP_PIPE_TX_DEPTH);

  typedef struct packed {
    logic [1:0]                 overflow;
    logic [CCIP_PIPE_OCC_W-1:0] c0_count;
    logic [CCIP_PIPE_OCC_W-1:0] c1_count;
  } t_ccip_pipe_status;

endpackage

// File: rtl/ccip_tx_elastic_fifo.sv
// rtl/ccip_tx_elastic_fifo.sv - elastic Tx request FIFO with FIU-gated drain
//
// Purpose: buffers one CCI-P Tx request channel. Drains one entry per cycle
// while the registered FIU almost-full is low; raises an early almost-full
// toward the AFU; records a sticky overflow when a push is dropped.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   push          - write push_data this cycle
//   push_data     - full channel payload
//   fiu_almfull   - registered FIU almost-full; blocks draining when high
//   out_valid     - registered: out_data holds a popped entry
//   out_data      - registered popped entry
//   count         - current entry count (0..DEPTH)
//   almfull       - registered (count >= DEPTH-AF_SLACK)
//   overflow      - sticky, set when a push is dropped while full

module ccip_tx_elastic_fifo
  import ccip_pipe_pkg::*;
#(
  parameter int  DEPTH     = CCIP_PIPE_TX_DEPTH,
  parameter int  AF_SLACK  = CCIP_PIPE_AF_SLACK,
  parameter type T_PAYLOAD = logic [7:0]
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  T_PAYLOAD                          push_data,
  input  logic                              fiu_almfull,
  output logic                              out_valid,
  output T_PAYLOAD                          out_data,
  output logic [ccip_pipe_occ_w(DEPTH)-1:0] count,
  output logic                              almfull,
  output logic                              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = ccip_pipe_occ_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_THRESH = CW'(DEPTH - AF_SLACK);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } t_state;

  t_state        state;
  t_state        state_next;

  T_PAYLOAD      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          pop;
  logic          accept;
  logic          drop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: ACTIVE exactly while the FIFO holds entries
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_ACTIVE;
      ST_ACTIVE: if (count_next == '0) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output logic: drain only from ACTIVE and only while the FIU has room
  always_comb begin
    pop = 1'b0;
    if (state == ST_ACTIVE) begin
      pop = !fiu_almfull;
    end
  end

  // A push at full is still accepted when a pop frees the slot in the same
  // cycle; the write then lands in the slot being read, which is safe since
  // the read captures the old contents on the same edge.
  assign drop   = push && (count == FULL_CNT) && !pop;
  assign accept = push && !drop;

  always_comb begin
    count_next = count;
    if (accept && !pop) begin
      count_next = count + 1'b1;
    end else if (!accept && pop) begin
      count_next = count - 1'b1;
    end
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      almfull   <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      // Flag follows the count register with one cycle of latency
      almfull   <= (count >= AF_THRESH);
      if (drop)   overflow <= 1'b1;
      out_valid <= pop;
    end
  end

  // Payload storage and output register carry no reset; out_valid qualifies
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
    if (pop)    out_data    <= mem[rd_ptr];
  end

endmodule

// File: rtl/ccip_if_pipe_buf.sv
// rtl/ccip_if_pipe_buf.sv - parametrised CCI-P interface stage with Tx buffering
//
// Purpose: sits between FIU and AFU. Rx is delayed RX_STAGES cycles. Tx c0/c1
// go through elastic FIFOs drained under FIU almost-full; Tx c2 is delayed
// C2_STAGES cycles. AFU almost-full flags come from the FIFO fill levels.
// Ports:
//   pClk                  - CCI-P clock
//   pck_cp2af_softReset_n - asynchronous active-low reset
//   fiu_sRx / afu_sRx     - Rx from FIU / Rx toward AFU
//   afu_sTx / fiu_sTx     - Tx from AFU / Tx toward FIU
//   c0_occupancy          - c0 FIFO entry count
//   c1_occupancy          - c1 FIFO entry count
//   tx_overflow           - sticky dropped-request flags {c1, c0}

module ccip_if_pipe_buf
  import ccip_if_pkg::*;
  import ccip_pipe_pkg::*;
#(
  parameter int RX_STAGES = 1,
  parameter int C2_STAGES = 1,
  parameter int TX_DEPTH  = CCIP_PIPE_TX_DEPTH,
  parameter int AF_SLACK  = CCIP_PIPE_AF_SLACK
) (
  input  logic                                 pClk,
  input  logic                                 pck_cp2af_softReset_n,
  input  t_if_ccip_Rx                          fiu_sRx,
  output t_if_ccip_Tx                          fiu_sTx,
  output t_if_ccip_Rx                          afu_sRx,
  input  t_if_ccip_Tx                          afu_sTx,
  output logic [ccip_pipe_occ_w(TX_DEPTH)-1:0] c0_occupancy,
  output logic [ccip_pipe_occ_w(TX_DEPTH)-1:0] c1_occupancy,
  output logic [1:0]                           tx_overflow
);

  t_if_ccip_Rx    rx_pipe [RX_STAGES];
  t_if_ccip_c2_Tx c2_pipe [C2_STAGES];

  logic           fiu_almfull_c0;
  logic           fiu_almfull_c1;

  t_if_ccip_c0_Tx c0_out;
  t_if_ccip_c1_Tx c1_out;
  logic           c0_out_valid;
  logic           c1_out_valid;
  logic           c0_almfull;
  logic           c1_almfull;
  logic           c0_overflow;
  logic           c1_overflow;

  // Rx register pipeline; all fields, valids included, shift together
  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      for (int i = 0; i < RX_STAGES; i++) begin
        rx_pipe[i] <= '0;
      end
    end else begin
      rx_pipe[0] <= fiu_sRx;
      for (int i = 1; i < RX_STAGES; i++) begin
        rx_pipe[i] <= rx_pipe[i-1];
      end
    end
  end

  // Drain control always uses the first stage so FIU backpressure reaction
  // time does not grow with RX_STAGES.
  assign fiu_almfull_c0 = rx_pipe[0].c0TxAlmFull;
  assign fiu_almfull_c1 = rx_pipe[0].c1TxAlmFull;

  always_comb begin
    afu_sRx             = rx_pipe[RX_STAGES-1];
    afu_sRx.c0TxAlmFull = c0_almfull;
    afu_sRx.c1TxAlmFull = c1_almfull;
  end

  ccip_tx_elastic_fifo #(
    .DEPTH     (TX_DEPTH),
    .AF_SLACK  (AF_SLACK),
    .T_PAYLOAD (t_if_ccip_c0_Tx)
  ) u_c0_fifo (
    .clk         (pClk),
    .rst_n       (pck_cp2af_softReset_n),
    .push        (afu_sTx.c0.valid),
    .push_data   (afu_sTx.c0),
    .fiu_almfull (fiu_almfull_c0),
    .out_valid   (c0_out_valid),
    .out_data    (c0_out),
    .count       (c0_occupancy),
    .almfull     (c0_almfull),
    .overflow    (c0_overflow)
  );

  ccip_tx_elastic_fifo #(
    .DEPTH     (TX_DEPTH),
    .AF_SLACK  (AF_SLACK),
    .T_PAYLOAD (t_if_ccip_c1_Tx)
  ) u_c1_fifo (
    .clk         (pClk),
    .rst_n       (pck_cp2af_softReset_n),
    .push        (afu_sTx.c1.valid),
    .push_data   (afu_sTx.c1),
    .fiu_almfull (fiu_almfull_c1),
    .out_valid   (c1_out_valid),
    .out_data    (c1_out),
    .count       (c1_occupancy),
    .almfull     (c1_almfull),
    .overflow    (c1_overflow)
  );

  assign tx_overflow = {c1_overflow, c0_overflow};

  // MMIO responses carry no flow control; plain delay line
  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      for (int i = 0; i < C2_STAGES; i++) begin
        c2_pipe[i] <= '0;
      end
    end else begin
      c2_pipe[0] <= afu_sTx.c2;
      for (int i = 1; i < C2_STAGES; i++) begin
        c2_pipe[i] <= c2_pipe[i-1];
      end
    end
  end

  // FIFO output registers hold stale payload when idle; valid comes from
  // the FIFO's own out_valid, not from the stored copy.
  always_comb begin
    fiu_sTx          = '0;
    fiu_sTx.c0       = c0_out;
    fiu_sTx.c0.valid = c0_out_valid;
    fiu_sTx.c1       = c1_out;
    fiu_sTx.c1.valid = c1_out_valid;
    fiu_sTx.c2       = c2_pipe[C2_STAGES-1];
  end

endmodule

// File: tb/tb_ccip_if_pipe_buf.sv
// tb/tb_ccip_if_pipe_buf.sv - self-checking bench for ccip_if_pipe_buf

module tb_ccip_if_pipe_buf;
  import ccip_if_pkg::*;

  localparam int RX_STAGES = 3;
  localparam int C2_STAGES = 2;
  localparam int TX_DEPTH  = 64;
  localparam int AF_SLACK  = 8;
  localparam int OCC_W     = $clog2(TX_DEPTH) + 1;
  localparam int AF_THRESH = TX_DEPTH - AF_SLACK;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  t_if_ccip_Rx      fiu_rx;
  t_if_ccip_Tx      fiu_tx;
  t_if_ccip_Rx      afu_rx;
  t_if_ccip_Tx      afu_tx;
  logic [OCC_W-1:0] c0_occ;
  logic [OCC_W-1:0] c1_occ;
  logic [1:0]       ovf;

  always #5 clk = ~clk;

  ccip_if_pipe_buf #(
    .RX_STAGES (RX_STAGES),
    .C2_STAGES (C2_STAGES),
    .TX_DEPTH  (TX_DEPTH),
    .AF_SLACK  (AF_SLACK)
  ) dut (
    .pClk                  (clk),
    .pck_cp2af_softReset_n (rst_n),
    .fiu_sRx               (fiu_rx),
    .fiu_sTx               (fiu_tx),
    .afu_sRx               (afu_rx),
    .afu_sTx               (afu_tx),
    .c0_occupancy          (c0_occ),
    .c1_occupancy          (c1_occ),
    .tx_overflow           (ovf)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  t_if_ccip_Rx    rx_hist[$];
  t_if_ccip_c2_Tx c2_hist[$];
  t_if_ccip_c0_Tx q0[$];
  t_if_ccip_c1_Tx q1[$];
  bit [1:0]       m_af;
  bit [1:0]       m_fiu_af;
  bit [1:0]       m_ovf;
  bit [1:0]       m_valid;
  t_if_ccip_c0_Tx m_out0;
  t_if_ccip_c1_Tx m_out1;

  task automatic model_reset();
    t_if_ccip_Rx    zr;
    t_if_ccip_c2_Tx z2;
    zr = '0;
    z2 = '0;
    rx_hist.delete();
    c2_hist.delete();
    q0.delete();
    q1.delete();
    for (int i = 0; i < RX_STAGES; i++) rx_hist.push_back(zr);
    for (int i = 0; i < C2_STAGES; i++) c2_hist.push_back(z2);
    m_af     = '0;
    m_fiu_af = '0;
    m_ovf    = '0;
    m_valid  = '0;
  endtask

  task automatic model_step();
    bit pop0;
    bit pop1;
    m_af[0] = (q0.size() >= AF_THRESH);
    m_af[1] = (q1.size() >= AF_THRESH);
    pop0 = (q0.size() > 0) && !m_fiu_af[0];
    pop1 = (q1.size() > 0) && !m_fiu_af[1];
    m_valid = {pop1, pop0};
    if (pop0) m_out0 = q0.pop_front();
    if (pop1) m_out1 = q1.pop_front();
    if (afu_tx.c0.valid) begin
      if (q0.size() < TX_DEPTH) q0.push_back(afu_tx.c0);
      else m_ovf[0] = 1'b1;
    end
    if (afu_tx.c1.valid) begin
      if (q1.size() < TX_DEPTH) q1.push_back(afu_tx.c1);
      else m_ovf[1] = 1'b1;
    end
    m_fiu_af = {fiu_rx.c1TxAlmFull, fiu_rx.c0TxAlmFull};
    rx_hist.push_back(fiu_rx);
    void'(rx_hist.pop_front());
    c2_hist.push_back(afu_tx.c2);
    void'(c2_hist.pop_front());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic compare();
    t_if_ccip_Rx    er;
    t_if_ccip_c2_Tx e2;
    er = rx_hist[0];
    e2 = c2_hist[0];
    chk("rx_c0_valids", 512'({afu_rx.c0.rspValid, afu_rx.c0.mmioRdValid, afu_rx.c0.mmioWrValid}),
        512'({er.c0.rspValid, er.c0.mmioRdValid, er.c0.mmioWrValid}));
    if (er.c0.rspValid || er.c0.mmioRdValid || er.c0.mmioWrValid) begin
      chk("rx_c0_hdr", 512'(afu_rx.c0.hdr), 512'(er.c0.hdr));
      chk("rx_c0_data", afu_rx.c0.data, er.c0.data);
    end
    chk("rx_c1_valid", 512'(afu_rx.c1.rspValid), 512'(er.c1.rspValid));
    if (er.c1.rspValid) chk("rx_c1_hdr", 512'(afu_rx.c1.hdr), 512'(er.c1.hdr));
    chk("afu_almfull", 512'({afu_rx.c1TxAlmFull, afu_rx.c0TxAlmFull}), 512'(m_af));
    chk("tx_c0_valid", 512'(fiu_tx.c0.valid), 512'(m_valid[0]));
    if (m_valid[0]) chk("tx_c0_hdr", 512'(fiu_tx.c0.hdr), 512'(m_out0.hdr));
    chk("tx_c1_valid", 512'(fiu_tx.c1.valid), 512'(m_valid[1]));
    if (m_valid[1]) begin
      chk("tx_c1_hdr", 512'(fiu_tx.c1.hdr), 512'(m_out1.hdr));
      chk("tx_c1_data", fiu_tx.c1.data, m_out1.data);
    end
    chk("tx_c2_valid", 512'(fiu_tx.c2.mmioRdValid), 512'(e2.mmioRdValid));
    if (e2.mmioRdValid) begin
      chk("tx_c2_hdr", 512'(fiu_tx.c2.hdr), 512'(e2.hdr));
      chk("tx_c2_data", 512'(fiu_tx.c2.data), 512'(e2.data));
    end
    chk("c0_occupancy", 512'(c0_occ), 512'(q0.size()));
    chk("c1_occupancy", 512'(c1_occ), 512'(q1.size()));
    chk("tx_overflow", 512'(ovf), 512'(m_ovf));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) compare();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_c0(input logic [15:0] md);
    afu_tx.c0               = '0;
    afu_tx.c0.valid         = 1'b1;
    afu_tx.c0.hdr.mdata     = md;
    afu_tx.c0.hdr.address   = {26'h0, md};
    afu_tx.c0.hdr.req_type  = 4'h0;
    tick();
    afu_tx.c0 = '0;
  endtask

  task automatic push_c1(input logic [15:0] md);
    afu_tx.c1               = '0;
    afu_tx.c1.valid         = 1'b1;
    afu_tx.c1.hdr.mdata     = md;
    afu_tx.c1.hdr.sop       = 1'b1;
    afu_tx.c1.data          = {16{16'hC1C1, md}};
    tick();
    afu_tx.c1 = '0;
  endtask

  initial begin
    int n;
    logic [15:0] exp_md;
    afu_tx = '0;
    fiu_rx = '0;
    rst_n  = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    chk("reset_c0_occ", 512'(c0_occ), 512'(0));
    chk("reset_ovf", 512'(ovf), 512'(0));
    chk("reset_c0_valid", 512'(fiu_tx.c0.valid), 512'(0));
    chk("reset_afu_af", 512'({afu_rx.c0TxAlmFull, afu_rx.c1TxAlmFull}), 512'(0));
    rst_n = 1'b1;
    tick();

    // Single c1 push: issued two cycles later
    push_c1(16'h0100);
    chk("t3_not_yet", 512'(fiu_tx.c1.valid), 512'(0));
    chk("t3_occ1", 512'(c1_occ), 512'(1));
    tick();
    chk("t3_issue", 512'(fiu_tx.c1.valid), 512'(1));
    chk("t3_mdata", 512'(fiu_tx.c1.hdr.mdata), 512'(16'h0100));
    // 20 back-to-back pushes stream straight through
    for (int i = 0; i < 20; i++) begin
      push_c1(16'h0200 + 16'(i));
      chk("t3_occ_le1", 512'(c1_occ <= 1), 512'(1));
    end
    repeat (3) tick();
    chk("t3_drained", 512'(c1_occ), 512'(0));

    // Rx pulse arrives RX_STAGES cycles later
    fiu_rx.c0.rspValid       = 1'b1;
    fiu_rx.c0.hdr.mdata      = 16'hBEEF;
    fiu_rx.c0.hdr.resp_type  = 4'h1;
    fiu_rx.c0.data           = {8{64'hDEAD_0000_BEEF_0005}};
    tick();
    fiu_rx.c0 = '0;
    tick();
    chk("t2_early", 512'(afu_rx.c0.rspValid), 512'(0));
    tick();
    chk("t2_arrive", 512'(afu_rx.c0.rspValid), 512'(1));
    chk("t2_mdata", 512'(afu_rx.c0.hdr.mdata), 512'(16'hBEEF));
    tick();
    chk("t2_gone", 512'(afu_rx.c0.rspValid), 512'(0));

    // c2 under c0/c1 backpressure; the c0 push here is the first of 56
    fiu_rx.c0TxAlmFull = 1'b1;
    fiu_rx.c1TxAlmFull = 1'b1;
    tick();
    afu_tx.c2.mmioRdValid = 1'b1;
    afu_tx.c2.hdr.tid     = 9'h1A3;
    afu_tx.c2.data        = 64'h0123_4567_89AB_CDEF;
    push_c0(16'h0400);
    afu_tx.c2 = '0;
    chk("t6_early", 512'(fiu_tx.c2.mmioRdValid), 512'(0));
    tick();
    chk("t6_valid", 512'(fiu_tx.c2.mmioRdValid), 512'(1));
    chk("t6_tid", 512'(fiu_tx.c2.hdr.tid), 512'(9'h1A3));
    chk("t6_c0_held", 512'(fiu_tx.c0.valid), 512'(0));
    tick();
    chk("t6_gone", 512'(fiu_tx.c2.mmioRdValid), 512'(0));

    // Fill c0 to 56 under FIU almost-full
    for (int i = 1; i < 56; i++) push_c0(16'h0400 + 16'(i));
    chk("t4_occ56", 512'(c0_occ), 512'(56));
    chk("t4_af_lag", 512'(afu_rx.c0TxAlmFull), 512'(0));
    tick();
    chk("t4_af_set", 512'(afu_rx.c0TxAlmFull), 512'(1));
    fiu_rx.c0TxAlmFull = 1'b0;
    n = 0;
    for (int i = 0; i < 62; i++) begin
      tick();
      if (fiu_tx.c0.valid) begin
        chk("t4_order", 512'(fiu_tx.c0.hdr.mdata), 512'(16'h0400 + 16'(n)));
        n++;
      end
    end
    chk("t4_issued", 512'(n), 512'(56));
    chk("t4_empty", 512'(c0_occ), 512'(0));
    chk("t4_af_clear", 512'(afu_rx.c0TxAlmFull), 512'(0));

    // Fill c1 to full, push+pop at full, then overflow
    for (int i = 0; i < 64; i++) push_c1(16'h0800 + 16'(i));
    chk("t5_full", 512'(c1_occ), 512'(64));
    chk("t5_no_ovf", 512'(ovf), 512'(0));
    fiu_rx.c1TxAlmFull = 1'b0;
    tick();
    fiu_rx.c1TxAlmFull = 1'b1;
    push_c1(16'h08FF);
    chk("t5_pp_occ", 512'(c1_occ), 512'(64));
    chk("t5_pp_no_ovf", 512'(ovf), 512'(0));
    chk("t5_pp_issue", 512'({fiu_tx.c1.valid, fiu_tx.c1.hdr.mdata}), 512'({1'b1, 16'h0800}));
    push_c1(16'h08EE);
    chk("t5_ovf_occ", 512'(c1_occ), 512'(64));
    chk("t5_ovf", 512'(ovf), 512'(2'b10));
    repeat (3) tick();
    chk("t5_sticky", 512'(ovf), 512'(2'b10));
    fiu_rx.c1TxAlmFull = 1'b0;
    n = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (fiu_tx.c1.valid) begin
        exp_md = (n < 63) ? 16'h0801 + 16'(n) : 16'h08FF;
        chk("t5_order", 512'(fiu_tx.c1.hdr.mdata), 512'(exp_md));
        n++;
      end
    end
    chk("t5_issued", 512'(n), 512'(64));
    chk("t5_still_sticky", 512'(ovf), 512'(2'b10));

    // Reset with 10 queued c0 requests
    fiu_rx.c0TxAlmFull = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) push_c0(16'h0500 + 16'(i));
    chk("t1_occ10", 512'(c0_occ), 512'(10));
    rst_n  = 1'b0;
    fiu_rx = '0;
    tick();
    chk("t1_rst_occ", 512'(c0_occ), 512'(0));
    chk("t1_rst_valid", 512'(fiu_tx.c0.valid), 512'(0));
    chk("t1_rst_ovf", 512'(ovf), 512'(0));
    rst_n = 1'b1;
    tick();
    push_c0(16'h0ABC);
    chk("t1_post_early", 512'(fiu_tx.c0.valid), 512'(0));
    tick();
    chk("t1_post_issue", 512'({fiu_tx.c0.valid, fiu_tx.c0.hdr.mdata}), 512'({1'b1, 16'h0ABC}));
    repeat (3) tick();
    chk("t1_no_stale", 512'(c0_occ), 512'(0));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
